sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. Adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags with a clear input. Adds a selectable first-word-fall-through (FWFT) read mode. Sits between producer and consumer blocks in the same clock domain as a drop-in buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
data_in  in  WIDTH  write data
w_en  in  1  write request
r_en  in  1  read request (pop)
clr_err  in  1  synchronous clear of overflow/underflow
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async assert, sync deassert): pointers=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. Memory contents are not reset.
- Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted iff w_en && !full. It stores data_in at wr_ptr, then wr_ptr++.
- Read accepted iff r_en && !empty. rd_ptr++.
- Acceptance uses the flag state at the clock edge; a read and a write in the same cycle do not unblock each other.
- Simultaneous accepted read+write: count unchanged, both pointers advance.
- At full, w_en+r_en gives read accepted, write dropped, and overflow set.
- At empty, w_en+r_en gives write accepted, read ignored, and underflow set.
- count is updated each cycle: +1 write only, -1 read only, otherwise hold. It is never outside 0..DEPTH.
- All status flags are registered and derived from the next-state count, so they are valid in the same cycle as the updated count.
- FWFT=0: data_out is registered and loads mem[rd_ptr] on the edge accepting a read (valid the cycle after r_en). It holds its last value otherwise, including on rejected reads.
- FWFT=1: data_out = mem[rd_ptr] whenever !empty, with zero latency from the write becoming visible. The first word appears the cycle after the write edge. r_en pops the word and data_out shows the next one. When empty, data_out holds its last value (0 after reset).
- overflow/underflow are sticky until clr_err=1 at an edge or reset. If clr_err and a new error occur in the same cycle, set wins.
- Reset mid-operation discards all contents immediately. Writes/reads in the reset cycle are ignored.

Decomposition:
- Package sync_fifo_pkg: clog2 helper function, default WIDTH/DEPTH constants, and the ADDR_W/CNT_W derivation so that benches and RTL agree.
- One sub-module, fifo_ram: simple dual-port register array (WIDTH x DEPTH), one write port, one asynchronous read port, no reset.
- Pointer, count, flag and error logic stay in sync_fifo_ext.

Test Plan:
- Reset, then write 0x00..0x0F (16 writes, DEPTH=16) -> count 1..16; almost_full from count 14; full at 16; empty=0 after the first write.
- From full, 16 reads (FWFT=0) -> data_out 0x00..0x0F in order, one cycle after each r_en; almost_empty when count<=2; empty and count=0 at end.
- Fill 16, read 2, write 0xA5, read 15 -> 15th read returns 0xA5 (pointer wrap); count returns to 0.
- Full FIFO, assert w_en with 0xEE -> write dropped, overflow=1 stays set, a later read returns the original head. Then clr_err -> overflow=0.
- Empty FIFO, r_en -> underflow=1, data_out unchanged. Then w_en+r_en together on empty -> count=1, underflow remains set.
- FWFT=1: write 0x3C -> data_out=0x3C next cycle without r_en. Write 0x5A, pulse r_en -> data_out=0x5A. Assert reset mid-stream -> count=0, empty=1 immediately.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and width derivations for sync_fifo_ext and its bench.
// Benches and RTL both call addr_w()/cnt_w(), so the pointer and occupancy
// widths cannot drift apart.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Ceiling log2. Written as a bounded loop so it folds at elaboration.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Pointer width: indexes DEPTH entries and wraps naturally.
   function automatic int addr_w(input int depth);
      return clog2(depth);
   endfunction

   // Occupancy width: needs one extra bit to represent count == DEPTH.
   function automatic int cnt_w(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ext_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_ext_if
// Bundles the FIFO's data, request and status signals.
//   master : producer/consumer side (drives data_in, w_en, r_en, clr_err)
//   slave  : FIFO side (drives data_out, full, empty, almost_*, count,
//            overflow, underflow)
// Request semantics: w_en / r_en are requests sampled at the rising edge.
// A write is taken only when full is low at that edge, a read only when empty
// is low at that edge; the requester uses full/empty as its "ready" and must
// not assume a request was honoured otherwise. Rejected requests raise the
// sticky overflow/underflow flags.
// -----------------------------------------------------------------------------
interface sync_fifo_ext_if
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   logic [WIDTH-1:0]         data_in;
   logic                     w_en;
   logic                     r_en;
   logic                     clr_err;
   logic [WIDTH-1:0]         data_out;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [cnt_w(DEPTH)-1:0]  count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output data_in, w_en, r_en, clr_err,
      input  data_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  data_in, w_en, r_en, clr_err,
      output data_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface : sync_fifo_ext_if

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port register array, WIDTH x DEPTH, no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data (mem[raddr])
// -----------------------------------------------------------------------------
module fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [addr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [addr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// sync_fifo_ext
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional
// first-word-fall-through read mode.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : sync_fifo_ext_if.slave (data_in, w_en, r_en, clr_err in;
//           data_out, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out)
// -----------------------------------------------------------------------------
module sync_fifo_ext
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic             clk,
   input  logic             reset,
   sync_fifo_ext_if.slave   bus
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(DEPTH);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
   localparam bit               FWFT_B   = (FWFT != 0);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic              full_q;
   logic              empty_q;
   logic              af_q;
   logic              ae_q;
   logic              ovf_q;
   logic              unf_q;
   logic [WIDTH-1:0]  dout_q;
   logic [WIDTH-1:0]  ram_rdata;

   logic              wr_acc;
   logic              rd_acc;
   logic              dout_load;

   // Acceptance looks only at the registered flags, so a simultaneous read
   // never frees room for a write at full, nor a write feed a read at empty.
   assign wr_acc = bus.w_en && !full_q;
   assign rd_acc = bus.r_en && !empty_q;

   always_comb begin
      count_nxt = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count_q + CNT_W'(1);
         2'b01:   count_nxt = count_q - CNT_W'(1);
         default: count_nxt = count_q;
      endcase
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Flags are computed from count_nxt so they line up with the new count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
         count_q <= count_nxt;
         full_q  <= (count_nxt == CNT_FULL);
         empty_q <= (count_nxt == '0);
         af_q    <= (count_nxt >= CNT_AF);
         ae_q    <= (count_nxt <= CNT_AE);
      end
   end

   // Sticky errors: a new error in the same cycle as clr_err wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (bus.w_en && full_q)  ovf_q <= 1'b1;
         else if (bus.clr_err)    ovf_q <= 1'b0;
         if (bus.r_en && empty_q) unf_q <= 1'b1;
         else if (bus.clr_err)    unf_q <= 1'b0;
      end
   end

   // Standard mode: dout_q is the output register, loaded on accepted reads.
   // FWFT mode: dout_q tracks the head word while non-empty so that once the
   // FIFO drains the output keeps showing the last word presented.
   assign dout_load = FWFT_B ? !empty_q : rd_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          dout_q <= '0;
      else if (dout_load) dout_q <= ram_rdata;
   end

   assign bus.data_out     = (FWFT_B && !empty_q) ? ram_rdata : dout_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule : sync_fifo_ext

// File: tb/tb_sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ext
// Directed bench for sync_fifo_ext: one instance in standard read mode and one
// in first-word-fall-through mode, both WIDTH=8, DEPTH=16, AF=14, AE=2.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ext;
   import sync_fifo_pkg::*;

   localparam int W = 8;
   localparam int D = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst0;
   logic rst1;

   always #5 clk = ~clk;

   sync_fifo_ext_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
   sync_fifo_ext_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

   sync_fifo_ext #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
   ) dut0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (bus0.slave)
   );

   sync_fifo_ext #(
      .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
   ) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1.slave)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // One clock cycle on dut0 with the given requests; outputs are sampled by
   // the caller 1 time unit after the edge.
   task automatic cyc0(input logic we, input logic re, input logic clr,
                       input logic [W-1:0] d);
      bus0.w_en    = we;
      bus0.r_en    = re;
      bus0.clr_err = clr;
      bus0.data_in = d;
      @(posedge clk);
      #1;
      bus0.w_en    = 1'b0;
      bus0.r_en    = 1'b0;
      bus0.clr_err = 1'b0;
   endtask

   task automatic cyc1(input logic we, input logic re, input logic [W-1:0] d);
      bus1.w_en    = we;
      bus1.r_en    = re;
      bus1.clr_err = 1'b0;
      bus1.data_in = d;
      @(posedge clk);
      #1;
      bus1.w_en = 1'b0;
      bus1.r_en = 1'b0;
   endtask

   task automatic push0(input logic [W-1:0] d);
      cyc0(1'b1, 1'b0, 1'b0, d);
      exp_q.push_back(d);
   endtask

   task automatic pop0_check(input string tag);
      logic [W-1:0] e;
      cyc0(1'b0, 1'b1, 1'b0, '0);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, bus0.data_out, e);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus0.data_in = '0; bus0.w_en = 1'b0; bus0.r_en = 1'b0; bus0.clr_err = 1'b0;
      bus1.data_in = '0; bus1.w_en = 1'b0; bus1.r_en = 1'b0; bus1.clr_err = 1'b0;
      rst0 = 1'b1;
      rst1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_count",  bus0.count, 0);
      check("rst_empty",  bus0.empty, 1);
      check("rst_ae",     bus0.almost_empty, 1);
      check("rst_full",   bus0.full, 0);
      check("rst_af",     bus0.almost_full, 0);
      check("rst_ovf",    bus0.overflow, 0);
      check("rst_unf",    bus0.underflow, 0);
      check("rst_dout",   bus0.data_out, 0);

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         push0(W'(i));
         check("fill_count", bus0.count, i + 1);
         check("fill_af",    bus0.almost_full, (i + 1 >= 14) ? 1 : 0);
         check("fill_full",  bus0.full, (i + 1 == 16) ? 1 : 0);
         check("fill_empty", bus0.empty, 0);
         check("fill_ae",    bus0.almost_empty, (i + 1 <= 2) ? 1 : 0);
      end

      // Drain, data appears the cycle after r_en
      for (int i = 0; i < 16; i++) begin
         pop0_check("drain_data");
         check("drain_count", bus0.count, 15 - i);
         check("drain_ae",    bus0.almost_empty, (15 - i <= 2) ? 1 : 0);
         check("drain_full",  bus0.full, 0);
      end
      check("drain_empty", bus0.empty, 1);

      // Pointer wrap: fill, read 2, write 0xA5, read 15
      for (int i = 0; i < 16; i++) push0(W'(8'h10 + i));
      pop0_check("wrap_rd");
      pop0_check("wrap_rd");
      push0(8'hA5);
      check("wrap_count15", bus0.count, 15);
      for (int i = 0; i < 15; i++) pop0_check("wrap_rd");
      check("wrap_last", bus0.data_out, 8'hA5);
      check("wrap_count0", bus0.count, 0);

      // Overflow
      for (int i = 0; i < 16; i++) push0(W'(8'h40 + i));
      cyc0(1'b1, 1'b0, 1'b0, 8'hEE);
      check("ovf_set",   bus0.overflow, 1);
      check("ovf_count", bus0.count, 16);
      cyc0(1'b0, 1'b0, 1'b0, '0);
      check("ovf_sticky", bus0.overflow, 1);
      pop0_check("ovf_head");
      check("ovf_head_val", bus0.data_out, 8'h40);
      // Full with read+write: read taken, write dropped
      push0(8'h50);
      check("fullrw_pre", bus0.full, 1);
      cyc0(1'b1, 1'b1, 1'b1, 8'hEF);
      void'(exp_q.pop_front());
      check("fullrw_count", bus0.count, 15);
      check("fullrw_data",  bus0.data_out, 8'h41);
      check("fullrw_ovf",   bus0.overflow, 1);
      cyc0(1'b0, 1'b0, 1'b1, '0);
      check("ovf_clr", bus0.overflow, 0);
      for (int i = 0; i < 15; i++) pop0_check("ovf_drain");
      check("ovf_drain_last", bus0.data_out, 8'h50);
      check("ovf_drain_cnt",  bus0.count, 0);

      // Underflow
      cyc0(1'b0, 1'b1, 1'b0, '0);
      check("unf_set",  bus0.underflow, 1);
      check("unf_dout", bus0.data_out, 8'h50);
      check("unf_cnt",  bus0.count, 0);
      cyc0(1'b1, 1'b1, 1'b0, 8'h77);
      exp_q.push_back(8'h77);
      check("emptyrw_count", bus0.count, 1);
      check("emptyrw_unf",   bus0.underflow, 1);
      check("emptyrw_dout",  bus0.data_out, 8'h50);
      cyc0(1'b0, 1'b0, 1'b1, '0);
      check("unf_clr", bus0.underflow, 0);
      pop0_check("unf_after");
      check("unf_after_val", bus0.data_out, 8'h77);

      // FWFT instance
      check("fw_rst_dout", bus1.data_out, 0);
      cyc1(1'b1, 1'b0, 8'h3C);
      check("fw_first",  bus1.data_out, 8'h3C);
      check("fw_cnt1",   bus1.count, 1);
      cyc1(1'b1, 1'b0, 8'h5A);
      check("fw_hold",   bus1.data_out, 8'h3C);
      check("fw_cnt2",   bus1.count, 2);
      cyc1(1'b0, 1'b1, '0);
      check("fw_pop",    bus1.data_out, 8'h5A);
      check("fw_cnt3",   bus1.count, 1);
      cyc1(1'b0, 1'b1, '0);
      check("fw_drain_dout",  bus1.data_out, 8'h5A);
      check("fw_drain_empty", bus1.empty, 1);
      cyc1(1'b1, 1'b0, 8'h11);
      cyc1(1'b1, 1'b0, 8'h22);
      check("fw_pre_rst_cnt", bus1.count, 2);
      check("fw_pre_rst_d",   bus1.data_out, 8'h11);
      rst1 = 1'b1;
      #1;
      check("fw_rst_cnt",   bus1.count, 0);
      check("fw_rst_empty", bus1.empty, 1);
      check("fw_rst_d",     bus1.data_out, 0);
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      cyc1(1'b1, 1'b0, 8'h99);
      check("fw_post_rst", bus1.data_out, 8'h99);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sync_fifo_ext
